// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone B4 classic arbiter with a strobe watchdog.
// The owner keeps the bus for its whole cyc; unanswered strobes end in a bus error.
module wb_arbiter2 #(
   parameter int DATA_WIDTH   = 128,
   parameter int ADDR_WIDTH   = 32,
   parameter int SELECT_WIDTH = DATA_WIDTH/8,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
   input  logic [DATA_WIDTH-1:0]   m0_dat_i,
   output logic [DATA_WIDTH-1:0]   m0_dat_o,
   input  logic                    m0_we_i,
   input  logic [SELECT_WIDTH-1:0] m0_sel_i,
   input  logic                    m0_stb_i,
   input  logic                    m0_cyc_i,
   output logic                    m0_ack_o,
   output logic                    m0_err_o,
   output logic                    m0_rty_o,
   input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
   input  logic [DATA_WIDTH-1:0]   m1_dat_i,
   output logic [DATA_WIDTH-1:0]   m1_dat_o,
   input  logic                    m1_we_i,
   input  logic [SELECT_WIDTH-1:0] m1_sel_i,
   input  logic                    m1_stb_i,
   input  logic                    m1_cyc_i,
   output logic                    m1_ack_o,
   output logic                    m1_err_o,
   output logic                    m1_rty_o,
   output logic [ADDR_WIDTH-1:0]   s_adr_o,
   output logic [DATA_WIDTH-1:0]   s_dat_o,
   output logic                    s_we_o,
   output logic [SELECT_WIDTH-1:0] s_sel_o,
   output logic                    s_stb_o,
   output logic                    s_cyc_o,
   input  logic [DATA_WIDTH-1:0]   s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   input  logic                    s_rty_i,
   output logic [1:0]              grant
);
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
   state_t state, nxt;
   logic last;
   logic [CW-1:0] cnt;
   logic g0, g1, stb_raw, term, hit;
   assign g0 = state == GRANT0;
   assign g1 = state == GRANT1;
   assign grant = {g1, g0};
   // last==1 favours m0 on simultaneous requests from IDLE
   always_comb
      nxt = g0 ? (m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE) :
            g1 ? (m1_cyc_i ? GRANT1 : m0_cyc_i ? GRANT0 : IDLE) :
            (m0_cyc_i && (!m1_cyc_i || last)) ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE;
   assign stb_raw = (g0 & m0_stb_i & m0_cyc_i) | (g1 & m1_stb_i & m1_cyc_i);
   assign term    = s_ack_i | s_err_i | s_rty_i;
   // a slave answer in the expiry cycle wins over the watchdog
   assign hit     = (TIMEOUT > 0) && stb_raw && !term && cnt == CW'(TIMEOUT);
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= nxt;
         if (nxt != IDLE) last <= nxt == GRANT1;
         cnt   <= (TIMEOUT == 0 || !stb_raw || term || hit || nxt != state) ? '0 : cnt + 1'b1;
      end
   end
   assign s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
   assign s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
   assign s_we_o   = (g0 & m0_we_i) | (g1 & m1_we_i);
   assign s_sel_o  = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
   assign s_cyc_o  = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
   assign s_stb_o  = stb_raw & ~hit;
   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = g0 & s_ack_i;
   assign m0_err_o = g0 & (s_err_i | hit);
   assign m0_rty_o = g0 & s_rty_i;
   assign m1_ack_o = g1 & s_ack_i;
   assign m1_err_o = g1 & (s_err_i | hit);
   assign m1_rty_o = g1 & s_rty_i;
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: scoreboard bench for wb_arbiter2 with a 4-cycle watchdog.
// Expected grant changes and termination pulses are queued with the stimulus.
module tb_wb_arbiter2;
   localparam int DW = 128, AW = 32, SW = 16;
   logic clk = 1'b0, rst;
   logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
   logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
   logic m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o, m0_rty_o;
   logic m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o, m1_rty_o;
   logic s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;
   logic [1:0] grant, prev_grant = 2'b00;
   logic [5:0] tv;
   logic [1:0] gq[$];
   logic [5:0] tq[$];
   int vectors = 0, misses = 0;
   localparam logic [5:0] T_M0_ACK = 6'b000001, T_M0_ERR = 6'b000010, T_M1_ACK = 6'b001000;
   always #5 clk = ~clk;
   wb_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
      .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
      .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant(grant)
   );
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      vectors++;
      if (got !== exp) begin
         misses++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic sample();
      @(negedge clk);
   endtask
   assign tv = {m1_rty_o, m1_err_o, m1_ack_o, m0_rty_o, m0_err_o, m0_ack_o};
   always @(negedge clk) begin
      if (grant !== prev_grant) begin
         if (gq.size() == 0) check("grant_unexpected", grant, prev_grant);
         else check("grant_seq", grant, gq.pop_front());
         prev_grant <= grant;
      end
      if (tv != 6'b0) begin
         if (tq.size() == 0) check("term_unexpected", tv, 6'b0);
         else check("term_seq", tv, tq.pop_front());
      end
   end
   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end
   initial begin
      rst = 1'b0;
      {m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i} = '0;
      {m0_we_i, m1_we_i, s_err_i, s_rty_i} = '0;
      s_dat_i = 128'hdead_beef_0123_4567_89ab_cdef_5a5a_a5a5;
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = 5'b11111;
      // reset held with both masters requesting and a stray slave ack
      repeat (2) tick();
      sample();
      check("rst_grant", grant, 2'b00);
      check("rst_s_cyc", s_cyc_o, 1'b0);
      check("rst_s_stb", s_stb_o, 1'b0);
      check("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
      check("rst_dat_o", m0_dat_o, s_dat_i);
      s_ack_i = 1'b0;
      gq.push_back(2'b01);
      gq.push_back(2'b00);
      rst = 1'b1;
      tick();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
      sample();
      check("rel_grant", grant, 2'b01);
      tick();
      // single m1 write, slave acks in the third strobe cycle
      m1_adr_i = 32'h0100_0000;
      m1_dat_i = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      m1_sel_i = 16'h000F;
      m1_we_i  = 1'b1;
      {m1_cyc_i, m1_stb_i} = 2'b11;
      gq.push_back(2'b10);
      tick();
      sample();
      check("single_adr", s_adr_o, 32'h0100_0000);
      check("single_sel", s_sel_o, 16'h000F);
      check("single_we", s_we_o, 1'b1);
      check("single_dat", s_dat_o, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
      check("single_stb", s_stb_o, 1'b1);
      check("single_m1_dat", m1_dat_o, s_dat_i);
      tick();
      tick();
      s_ack_i = 1'b1;
      tq.push_back(T_M1_ACK);
      sample();
      check("single_m1_ack", m1_ack_o, 1'b1);
      check("single_m0_ack", m0_ack_o, 1'b0);
      tick();
      s_ack_i = 1'b0;
      {m1_cyc_i, m1_stb_i, m1_we_i} = '0;
      gq.push_back(2'b00);
      sample();
      check("single_ack_pulse", m1_ack_o, 1'b0);
      tick();
      // contention: four single-beat transactions each, zero-bubble alternation
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = 4'b1111;
      for (int k = 0; k < 8; k++) gq.push_back(k % 2 ? 2'b10 : 2'b01);
      gq.push_back(2'b00);
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k > 0 && k - 1 <= 5) begin
            if ((k - 1) % 2) {m1_cyc_i, m1_stb_i} = 2'b11;
            else {m0_cyc_i, m0_stb_i} = 2'b11;
         end
         s_ack_i = 1'b1;
         tq.push_back(k % 2 ? T_M1_ACK : T_M0_ACK);
         sample();
         check("fair_grant", grant, k % 2 ? 2'b10 : 2'b01);
         tick();
         s_ack_i = 1'b0;
         if (k % 2) {m1_cyc_i, m1_stb_i} = 2'b00;
         else {m0_cyc_i, m0_stb_i} = 2'b00;
      end
      tick();
      // no preemption: m0 owns the bus for 20 cycles, m1 asks at cycle 2
      m0_cyc_i = 1'b1;
      gq.push_back(2'b01);
      tick();
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) tick();
         m0_stb_i = (c % 4 == 1);
         s_ack_i  = m0_stb_i;
         if (m0_stb_i) tq.push_back(T_M0_ACK);
         if (c == 2) m1_cyc_i = 1'b1;
         sample();
         check("nopre_grant", grant, 2'b01);
      end
      tick();
      {m0_cyc_i, m0_stb_i, s_ack_i} = '0;
      gq.push_back(2'b10);
      gq.push_back(2'b00);
      sample();
      check("nopre_hold", grant, 2'b01);
      tick();
      m1_cyc_i = 1'b0;
      sample();
      check("nopre_handover", grant, 2'b10);
      tick();
      // watchdog: unanswered strobe errors in its fifth cycle
      m0_cyc_i = 1'b1;
      gq.push_back(2'b01);
      tick();
      m0_stb_i = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         if (c > 1) tick();
         if (c == 5) tq.push_back(T_M0_ERR);
         sample();
         check("wd_err", m0_err_o, c == 5);
         check("wd_stb", s_stb_o, c != 5);
      end
      tick();
      m0_stb_i = 1'b0;
      tick();
      m0_stb_i = 1'b1;
      // slave ack exactly at expiry wins over the watchdog
      for (int c = 1; c <= 5; c++) begin
         if (c > 1) tick();
         if (c == 5) begin
            s_ack_i = 1'b1;
            tq.push_back(T_M0_ACK);
         end
         sample();
         check("wd_ack", m0_ack_o, c == 5);
         check("wd_ack_noerr", m0_err_o, 1'b0);
      end
      tick();
      {m0_cyc_i, m0_stb_i, s_ack_i} = '0;
      gq.push_back(2'b00);
      tick();
      // asynchronous reset in the middle of an m1 strobe
      m1_cyc_i = 1'b1;
      gq.push_back(2'b10);
      tick();
      {m1_stb_i, m0_cyc_i, m0_stb_i} = 3'b111;
      sample();
      check("mr_s_cyc_pre", s_cyc_o, 1'b1);
      check("mr_s_stb_pre", s_stb_o, 1'b1);
      #2;
      gq.push_back(2'b00);
      rst = 1'b0;
      #1;
      check("mr_s_cyc", s_cyc_o, 1'b0);
      check("mr_s_stb", s_stb_o, 1'b0);
      check("mr_grant", grant, 2'b00);
      sample();
      #1;
      gq.push_back(2'b01);
      rst = 1'b1;
      tick();
      {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
      gq.push_back(2'b00);
      sample();
      check("mr_restart", grant, 2'b01);
      repeat (3) tick();
      check("gq_left", gq.size(), 0);
      check("tq_left", tq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
      $finish;
   end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone B4 (classic, non-pipelined) arbiter that shares one slave port, the CPU host bus, between the CPU and a second bus master such as a future DMA or VGA blitter. It sits between the masters and the host `wb_mux_host` input. Arbitration is round-robin, and the current owner holds the bus for its whole `cyc` cycle. A watchdog terminates any strobe the slave never answers by returning a bus error.

## Interface
Parameters:
- `DATA_WIDTH`, 128: data bus width.
- `ADDR_WIDTH`, 32: address width.
- `SELECT_WIDTH`, `DATA_WIDTH/8`: byte-select width.
- `TIMEOUT`, 255: watchdog limit, in unanswered strobe cycles. 0 disables the watchdog.

Ports:
- `clk`, in, 1: single clock. All logic is in this domain.
- `rst`, in, 1: asynchronous, active-low reset.
- `m0_adr_i`/`m1_adr_i`, in, `ADDR_WIDTH`: master address. m0 is the CPU.
- `m0_dat_i`/`m1_dat_i`, in, `DATA_WIDTH`: master write data.
- `m0_dat_o`/`m1_dat_o`, out, `DATA_WIDTH`: read data. Both carry `s_dat_i` unconditionally.
- `m0_we_i`/`m1_we_i`, in, 1: write enable.
- `m0_sel_i`/`m1_sel_i`, in, `SELECT_WIDTH`: byte selects.
- `m0_stb_i`/`m1_stb_i`, in, 1: strobe.
- `m0_cyc_i`/`m1_cyc_i`, in, 1: cycle, used as the bus request.
- `m0_ack_o`/`m1_ack_o`, `m0_err_o`/`m1_err_o`, `m0_rty_o`/`m1_rty_o`, out, 1: terminations. Only the granted master sees them.
- `s_adr_o`, out, `ADDR_WIDTH`; `s_dat_o`, out, `DATA_WIDTH`; `s_we_o`, out, 1; `s_sel_o`, out, `SELECT_WIDTH`; `s_stb_o`, out, 1; `s_cyc_o`, out, 1: to the slave.
- `s_dat_i`, in, `DATA_WIDTH`; `s_ack_i`, `s_err_i`, `s_rty_i`, in, 1: from the slave.
- `grant`, out, 2: one-hot owner, `2'b00` when idle.

## Operation
- **States:**
  - IDLE, GRANT0, GRANT1, held in registers.
  - `last` records the most recently granted master. It resets to 1, so m0 wins the first contention.
- **From IDLE:**
  - Only one `cyc` asserted: that master is granted.
  - Both asserted: the master ≠ `last` is granted.
  - Neither asserted: stay in IDLE.
- **From GRANTx:**
  - While `mx_cyc_i` stays high, remain in GRANTx. No preemption.
  - When `mx_cyc_i` falls and the other master's `cyc` is high, go directly to GRANTy.
  - Otherwise go to IDLE.
  - `last` is updated on every entry into a GRANT state.
- **Forwarding:**
  - In GRANTx, `s_adr/dat/we/sel/cyc_o` follow master x combinationally.
  - `s_stb_o` = `mx_stb_i` & `mx_cyc_i`.
  - In IDLE all `s_*` outputs are 0.
- **Return path:**
  - `s_ack_i`, `s_err_i` and `s_rty_i` are routed only to the granted master.
  - The non-granted master's ack/err/rty are held at 0.
- **Watchdog (TIMEOUT>0):**
  - A counter of width `clog2(TIMEOUT+1)` increments each cycle that `s_stb_o` is high and no slave termination arrives.
  - It clears on any termination, when `s_stb_o` is low, or on a grant change.
  - When the count equals TIMEOUT:
    - The granted master's `err_o` is 1 for that cycle, with ack 0.
    - `s_stb_o` is forced to 0 for that cycle.
    - The counter clears on the next edge.
  - If the slave answers in the same cycle the counter hits TIMEOUT, the slave termination wins and no err is generated.
- **Reset:**
  - Asserting `rst` low at any time, including mid-transfer, immediately forces IDLE, `last`=1 and counter=0.
  - All outputs go to 0: `grant`, `s_*`, and every termination.
  - `dat_o` mirrors `s_dat_i`.

## Timing
- Grant latency is one clock: `cyc` is sampled at edge N, `grant` and the `s_*` forwarding are valid after edge N.
- Handover is zero-bubble: the edge that samples the owner's `cyc` low also grants the waiting master.
- The data and termination path is fully combinational, adding no cycles to a slave access.
- Watchdog error arrives in the cycle after TIMEOUT unanswered strobe cycles, i.e. TIMEOUT+1 cycles after `stb` rises.

## Test plan
- **Reset:** hold `rst`=0, drive m0/m1 `cyc`/`stb`=1 → `grant`=00, `s_cyc_o`=0, all acks 0. Release reset → `grant`=01 after the first edge.
- **Single master:** m1 issues a write to 0x01000000 with sel=16'h000F and the slave acks after 3 cycles → `m1_ack_o` pulses one cycle, `m0_ack_o` stays 0, `s_adr_o`=0x01000000.
- **Contention fairness:** both hold `cyc` for 4 back-to-back single-beat transactions each → grants alternate 01,10,01,10…, with no IDLE cycle between handovers.
- **No preemption:** m0 holds `cyc` for 20 cycles with 5 strobes; m1 requests at cycle 2 → `grant` stays 01 until m0's `cyc` falls, then 10 on the next edge.
- **Watchdog:** TIMEOUT=4, slave never acks, m0 strobes → `m0_err_o`=1 in cycle 5 after `stb` rises, `s_stb_o`=0 that cycle. Slave ack exactly at count 4 → ack passed through, no err.
- **Mid-transfer reset:** assert `rst` low while GRANT1 has `stb` high → `s_cyc_o`/`s_stb_o` drop asynchronously the same cycle; after release, arbitration restarts with m0 favoured.
